// File: rtl/rf_wb_queue.sv
// rf_wb_queue: in-order write-back queue in front of the register-file write port.
// Producers push {rdc,data}; one entry drains per cycle into the register file.
// Two combinational lookups expose the youngest pending value per register to decode.
module rf_wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ena,
   input  logic          wb_valid,
   output logic          wb_ready,
   input  logic [4:0]    wb_rdc,
   input  logic [31:0]   wb_data,
   input  logic          rf_hold,
   output logic          RF_w,
   output logic [4:0]    rdc,
   output logic [31:0]   rd,
   input  logic [4:0]    fw_rsc,
   output logic          fw_rs_hit,
   output logic [31:0]   fw_rs,
   input  logic [4:0]    fw_rtc,
   output logic          fw_rt_hit,
   output logic [31:0]   fw_rt,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [DEPTH-1:0] ent_vld;
   logic [4:0]       ent_rdc  [DEPTH];
   logic [31:0]      ent_data [DEPTH];

   logic push_acc;
   logic do_store;

   // Ready is held low while reset is asserted; full is judged by count only.
   assign wb_ready = reset && ena && (count != FULL);
   assign push_acc = wb_valid && wb_ready;
   // Writes to r0 complete the handshake but are discarded.
   assign do_store = push_acc && (wb_rdc != 5'd0);

   // Head entry is presented straight from registers so it is stable all cycle.
   assign RF_w = ena && !rf_hold && (count != '0);
   assign rdc  = RF_w ? ent_rdc[rd_ptr]  : 5'd0;
   assign rd   = RF_w ? ent_data[rd_ptr] : 32'd0;

   // Control state: pointers, occupancy and per-entry valid bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ent_vld <= '0;
      end else begin
         if (RF_w) begin
            rd_ptr          <= rd_ptr + 1'b1;
            ent_vld[rd_ptr] <= 1'b0;
         end
         if (do_store) begin
            wr_ptr          <= wr_ptr + 1'b1;
            ent_vld[wr_ptr] <= 1'b1;
         end
         case ({do_store, RF_w})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage; only ever read through valid entries, so no reset needed.
   always_ff @(posedge clk) begin
      if (do_store) begin
         ent_rdc[wr_ptr]  <= wb_rdc;
         ent_data[wr_ptr] <= wb_data;
      end
   end

   // rs lookup: scan oldest to youngest so the youngest match is the one kept.
   always_comb begin : fw_rs_search
      logic [AW-1:0] idx;
      fw_rs_hit = 1'b0;
      fw_rs     = 32'd0;
      idx       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if (ent_vld[idx] && (ent_rdc[idx] == fw_rsc) && (fw_rsc != 5'd0)) begin
            fw_rs_hit = 1'b1;
            fw_rs     = ent_data[idx];
         end
      end
   end

   // rt lookup: same search as rs on the second query port.
   always_comb begin : fw_rt_search
      logic [AW-1:0] idx;
      fw_rt_hit = 1'b0;
      fw_rt     = 32'd0;
      idx       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if (ent_vld[idx] && (ent_rdc[idx] == fw_rtc) && (fw_rtc != 5'd0)) begin
            fw_rt_hit = 1'b1;
            fw_rt     = ent_data[idx];
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: directed and randomized stimulus against a queue-based reference model,
// with register-file writes checked by a scoreboard in a separate monitor.
module tb_rf_wb_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          ena;
   logic          wb_valid;
   logic          wb_ready;
   logic [4:0]    wb_rdc;
   logic [31:0]   wb_data;
   logic          rf_hold;
   logic          RF_w;
   logic [4:0]    rdc;
   logic [31:0]   rd;
   logic [4:0]    fw_rsc;
   logic          fw_rs_hit;
   logic [31:0]   fw_rs;
   logic [4:0]    fw_rtc;
   logic          fw_rt_hit;
   logic [31:0]   fw_rt;
   logic [AW:0]   count;

   ent_t mq[$];   // reference model: pending entries, oldest first
   ent_t sb[$];   // scoreboard: register-file writes still expected

   int errors = 0;
   int checks = 0;

   rf_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .ena(ena),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdc(wb_rdc), .wb_data(wb_data),
      .rf_hold(rf_hold), .RF_w(RF_w), .rdc(rdc), .rd(rd),
      .fw_rsc(fw_rsc), .fw_rs_hit(fw_rs_hit), .fw_rs(fw_rs),
      .fw_rtc(fw_rtc), .fw_rt_hit(fw_rt_hit), .fw_rt(fw_rt),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model advances on each clock edge from the inputs presented that cycle.
   always @(posedge clk) begin
      if (reset) begin
         automatic bit   pop = ena && !rf_hold && (mq.size() != 0);
         automatic bit   acc = wb_valid && ena && (mq.size() < DEPTH);
         automatic ent_t e;
         e.r = wb_rdc;
         e.d = wb_data;
         if (pop) void'(mq.pop_front());
         if (acc && (wb_rdc != 5'd0)) begin
            mq.push_back(e);
            sb.push_back(e);
         end
      end
   end

   // Reset discards everything pending, including expected writes.
   always @(negedge reset) begin
      mq.delete();
      sb.delete();
   end

   // Monitor: mid-cycle comparison of handshake, drain and forwarding outputs.
   always @(negedge clk) begin
      automatic bit          exp_rdy = reset && ena && (mq.size() < DEPTH);
      automatic bit          exp_rfw = ena && !rf_hold && (mq.size() != 0);
      automatic bit          ha = 1'b0, hb = 1'b0;
      automatic logic [31:0] da = 32'd0, db = 32'd0;
      automatic ent_t        e;
      chk("wb_ready", 32'(wb_ready), 32'(exp_rdy));
      chk("RF_w", 32'(RF_w), 32'(exp_rfw));
      chk("count", 32'(count), 32'(mq.size()));
      if (RF_w) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", 32'(RF_w), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rdc", 32'(rdc), 32'(e.r));
            chk("rd", rd, e.d);
         end
      end else begin
         chk("rdc_idle", 32'(rdc), 32'd0);
         chk("rd_idle", rd, 32'd0);
      end
      foreach (mq[i]) begin
         if (fw_rsc != 5'd0 && mq[i].r == fw_rsc) begin ha = 1'b1; da = mq[i].d; end
         if (fw_rtc != 5'd0 && mq[i].r == fw_rtc) begin hb = 1'b1; db = mq[i].d; end
      end
      chk("fw_rs_hit", 32'(fw_rs_hit), 32'(ha));
      chk("fw_rs", fw_rs, da);
      chk("fw_rt_hit", 32'(fw_rt_hit), 32'(hb));
      chk("fw_rt", fw_rt, db);
   end

   task automatic step(input bit rs, input bit en, input bit v, input logic [4:0] r,
                       input logic [31:0] d, input bit h, input logic [4:0] qa,
                       input logic [4:0] qb);
      @(posedge clk);
      #1;
      reset    = rs;
      ena      = en;
      wb_valid = v;
      wb_rdc   = r;
      wb_data  = d;
      rf_hold  = h;
      fw_rsc   = qa;
      fw_rtc   = qb;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
   endtask

   initial begin
      reset = 1'b0; ena = 1'b1; wb_valid = 1'b0; wb_rdc = '0; wb_data = '0;
      rf_hold = 1'b0; fw_rsc = '0; fw_rtc = '0;

      // Reset held with clock running, then released.
      for (int i = 0; i < 3; i++) step(0, 1, 1, 5'd3, 32'h1234, 0, 5'd3, 5'd0);
      idle(2);

      // Single push into an empty queue drains on the next cycle.
      step(1, 1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd0);
      idle(3);

      // Fill while held, attempt a fifth push, then release the hold.
      for (int i = 1; i <= 4; i++) step(1, 1, 1, 5'(i), 32'(i * 16 + i), 1, 5'd2, 5'd4);
      step(1, 1, 1, 5'd9, 32'h99, 1, 5'd9, 5'd1);
      step(1, 1, 1, 5'd9, 32'h99, 1, 5'd3, 5'd0);
      idle(6);

      // Two pending writes to r7: lookup must return the younger one.
      step(1, 1, 1, 5'd7, 32'h11, 1, 5'd7, 5'd0);
      step(1, 1, 1, 5'd7, 32'h22, 1, 5'd7, 5'd0);
      step(1, 1, 0, 5'd0, 32'h0, 1, 5'd7, 5'd0);
      step(1, 1, 0, 5'd0, 32'h0, 0, 5'd7, 5'd7);
      idle(3);

      // Write to r0 is accepted but never reaches the register file.
      step(1, 1, 1, 5'd0, 32'hFFFF, 0, 5'd0, 5'd0);
      idle(2);

      // Full queue, reset asserted while draining, then released.
      for (int i = 0; i < 4; i++) step(1, 1, 1, 5'(10 + i), 32'hA0 + 32'(i), 1, 5'd11, 5'd13);
      step(1, 1, 0, 5'd0, 32'h0, 0, 5'd12, 5'd10);
      step(0, 1, 0, 5'd0, 32'h0, 0, 5'd12, 5'd10);
      step(0, 1, 0, 5'd0, 32'h0, 0, 5'd12, 5'd10);
      idle(4);

      // Enable low freezes the queue and blocks pushes.
      step(1, 1, 1, 5'd6, 32'h66, 0, 5'd6, 5'd0);
      step(1, 0, 1, 5'd8, 32'h88, 0, 5'd6, 5'd8);
      step(1, 0, 0, 5'd0, 32'h0, 0, 5'd6, 5'd8);
      idle(3);

      // Randomized traffic with wrap-around, stalls, disables and occasional resets.
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 64) != 0, ($urandom % 8) != 0, ($urandom % 4) != 0,
              5'($urandom % 8), $urandom, ($urandom % 3) == 0,
              5'($urandom % 8), 5'($urandom % 8));
      end

      // Drain whatever is left; every expected write must have been seen.
      idle(DEPTH + 4);
      @(negedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
